// File: rtl/lc3_pkg.sv
// ============================================================================
//  Module   : lc3_pkg
//  Brief    : Shared types and constants for the LC-3 cycle sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC   = 2'd2;
    localparam logic [1:0] PH_STORE  = 2'd3;

    localparam int PERF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/phase_ctr.sv
// ============================================================================
//  Module   : phase_ctr
//  Brief    : 2-bit wrapping phase counter with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_ctr (
    input  logic       clk,
    input  logic       clr,
    input  logic       incr,
    output logic [1:0] q
);

    logic [1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= 2'd0;
        end else if (incr) begin
            r_q <= r_q + 2'd1;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/cycle_ctrl.sv
// ============================================================================
//  Module   : cycle_ctrl
//  Brief    : LC-3 instruction-cycle sequencer (FETCH/DECODE/EXECUTE/STORE)
//             with memory-handshake stalls and load strobes.
//             Optional CYCLE_CTRL_PERF_EN adds retired/stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cycle_ctrl
    import lc3_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  need_mem,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic [1:0]            phase,
    output logic                  ld_ir,
    output logic                  ld_pc,
    output logic                  ld_reg,
    output logic                  retire,
    output logic                  running
`ifdef CYCLE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] retired_cnt,
    output logic [PERF_CNT_W-1:0] stall_cnt
`endif
);

    ctrl_state_t r_state;
    logic [1:0]  w_phase;
    logic        w_run;
    logic        w_adv;
    logic        w_halt_now;
    logic        w_clr;

    assign w_run = (r_state == RUN);

    // Strobes and mem_req are decoded from state/phase; mem_ready only gates the advance.
    always_comb begin
        mem_req = 1'b0;
        ld_ir   = 1'b0;
        ld_pc   = 1'b0;
        ld_reg  = 1'b0;
        retire  = 1'b0;
        w_adv   = 1'b0;
        if (w_run) begin
            case (w_phase)
                PH_FETCH: begin
                    mem_req = 1'b1;
                    ld_ir   = mem_ready;
                    w_adv   = mem_ready;
                end
                PH_DECODE: begin
                    ld_pc = 1'b1;
                    w_adv = 1'b1;
                end
                PH_EXEC: begin
                    mem_req = need_mem;
                    w_adv   = ~need_mem | mem_ready;
                end
                default: begin
                    ld_reg = 1'b1;
                    retire = 1'b1;
                    w_adv  = 1'b1;
                end
            endcase
        end
    end

    assign w_halt_now = w_run && (w_phase == PH_STORE) && halt_req;
    assign w_clr      = reset | w_halt_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_halt_now) begin
                        r_state <= HALTED;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    phase_ctr u_phase_ctr (
        .clk  (clk),
        .clr  (w_clr),
        .incr (w_adv),
        .q    (w_phase)
    );

    assign phase   = w_phase;
    assign running = w_run;

`ifdef CYCLE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] r_retired_cnt;
    logic [PERF_CNT_W-1:0] r_stall_cnt;

    // Retired count wraps; stall count saturates so long stalls never alias to small values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (retire) begin
                r_retired_cnt <= r_retired_cnt + 1'b1;
            end
            if (mem_req && !mem_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cycle_ctrl.sv
// ============================================================================
//  Module   : tb_cycle_ctrl
//  Brief    : Instruction-level scoreboard bench for cycle_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        need_mem = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [1:0]  phase;
    logic        ld_ir;
    logic        ld_pc;
    logic        ld_reg;
    logic        retire;
    logic        running;
`ifdef CYCLE_CTRL_PERF_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;
`endif

    cycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .halt_req  (halt_req),
        .need_mem  (need_mem),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .phase     (phase),
        .ld_ir     (ld_ir),
        .ld_pc     (ld_pc),
        .ld_reg    (ld_reg),
        .retire    (retire),
        .running   (running)
`ifdef CYCLE_CTRL_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected outputs for one cycle: {phase, mem_req, ld_ir, ld_pc, ld_reg, retire, running}
    typedef struct {
        logic [7:0]  sig;
        int unsigned rc;
        int unsigned sc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned m_ret = 0;
    int unsigned m_stall = 0;

    localparam logic [7:0] IDLE_E = 8'b0000_0000;

    function automatic logic [7:0] mk(input int ph, input bit mreq, ir, pc, rg, run);
        logic [1:0] p;
        p = ph[1:0];
        return {p, mreq, ir, pc, rg, rg, run};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Applies one cycle of inputs and records what the outputs must be in that cycle.
    task automatic drive(input bit rst, st, hr, nm, mr, input logic [7:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        reset     = rst;
        start     = st;
        halt_req  = hr;
        need_mem  = nm;
        mem_ready = mr;
        x.sig = e;
        x.rc  = m_ret;
        x.sc  = m_stall;
        exp_q.push_back(x);
        if (rst) begin
            m_ret   = 0;
            m_stall = 0;
        end else begin
            if (e[1]) m_ret = (m_ret + 1) & 32'hFFFF;
            if (e[5] && !mr && m_stall < 32'hFFFF) m_stall = m_stall + 1;
        end
    endtask

    // One full instruction starting at FETCH: fw fetch waits, ew execute waits (if nm).
    task automatic instr(input int fw, input int ew, input bit nm, input bit hlt);
        for (int i = 0; i < fw; i++) drive(0, rb(), rb(), rb(), 0, mk(0, 1, 0, 0, 0, 1));
        drive(0, rb(), rb(), rb(), 1, mk(0, 1, 1, 0, 0, 1));
        drive(0, rb(), rb(), nm, rb(), mk(1, 0, 0, 1, 0, 1));
        if (nm) begin
            for (int i = 0; i < ew; i++) drive(0, rb(), rb(), 1, 0, mk(2, 1, 0, 0, 0, 1));
            drive(0, rb(), rb(), 1, 1, mk(2, 1, 0, 0, 0, 1));
        end else begin
            drive(0, rb(), rb(), 0, rb(), mk(2, 0, 0, 0, 0, 1));
        end
        drive(0, rb(), hlt, rb(), rb(), mk(3, 0, 0, 0, 1, 1));
    endtask

    // From IDLE/HALTED: k idle cycles, then a start cycle; next cycle is FETCH.
    task automatic resume(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, rb(), rb(), rb(), IDLE_E);
        drive(0, 1, rb(), rb(), rb(), IDLE_E);
    endtask

    // Reset during a FETCH stall; a late mem_ready must not produce ld_ir.
    task automatic reset_stall(input int fw);
        for (int i = 0; i < fw; i++) drive(0, rb(), rb(), rb(), 0, mk(0, 1, 0, 0, 0, 1));
        drive(1, rb(), rb(), rb(), 0, mk(0, 1, 0, 0, 0, 1));
        drive(0, 0, rb(), rb(), 1, IDLE_E);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            exp_t x;
            logic [7:0] act;
            x   = exp_q.pop_front();
            act = {phase, mem_req, ld_ir, ld_pc, ld_reg, retire, running};
            checks++;
            if (act !== x.sig) begin
                failures++;
                $display("FAIL outputs t=%0t act{ph,req,ir,pc,reg,ret,run}=%b exp=%b",
                         $time, act, x.sig);
            end
`ifdef CYCLE_CTRL_PERF_EN
            checks++;
            if (retired_cnt !== 16'(x.rc)) begin
                failures++;
                $display("FAIL retired_cnt t=%0t act=%0d exp=%0d", $time, retired_cnt, x.rc);
            end
            checks++;
            if (stall_cnt !== 16'(x.sc)) begin
                failures++;
                $display("FAIL stall_cnt t=%0t act=%0d exp=%0d", $time, stall_cnt, x.sc);
            end
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fw, ew, r;
        bit nm;
        repeat (2) @(posedge clk);
        drive(0, 0, 0, 0, 1, IDLE_E);
        drive(0, 0, 1, 1, 0, IDLE_E);
        resume(1);
        // zero-wait back-to-back, then fetch wait, execute wait, no-mem execute
        repeat (3) instr(0, 0, 0, 0);
        instr(3, 0, 0, 0);
        instr(0, 2, 1, 0);
        instr(0, 0, 0, 0);
        // halt and resume
        instr(0, 0, 0, 1);
        resume(2);
        instr(0, 0, 0, 0);
        reset_stall(2);
        resume(0);
        // five instructions with three waits in total, from a fresh reset
        reset_stall(0);
        resume(0);
        instr(1, 0, 0, 0);
        instr(0, 2, 1, 0);
        instr(0, 0, 1, 0);
        instr(0, 0, 0, 0);
        instr(0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, IDLE_E);
        resume(0);
        for (int n = 0; n < 60; n++) begin
            fw = $urandom_range(0, 3);
            ew = $urandom_range(0, 3);
            nm = rb();
            r  = $urandom_range(0, 15);
            if (r == 0) begin
                reset_stall(fw);
                resume($urandom_range(0, 2));
            end else if (r < 4) begin
                instr(fw, ew, nm, 1);
                resume($urandom_range(0, 2));
            end else begin
                instr(fw, ew, nm, 0);
            end
        end
        instr(0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, IDLE_E);
        drive(1, 0, 0, 0, 0, IDLE_E);
        drive(0, 0, 0, 0, 1, IDLE_E);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cycle_ctrl.md
# cycle_ctrl

Instruction-cycle sequencer for the LC-3 core. It steps a 2-bit phase counter through FETCH, DECODE, EXECUTE and STORE. It stalls the counter on a memory handshake and emits the one-cycle load strobes that the IR, PC and register file consume. It sits between the top-level run/halt control and the datapath, and is the only driver of the phase counter's increment input.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- start  input  1  level; leaves IDLE or HALTED and begins fetching.
- halt_req  input  1  level; request to stop at the next instruction boundary.
- need_mem  input  1  from decode; current instruction makes a data-memory access in EXECUTE.
- mem_ready  input  1  memory completes the access requested by mem_req this cycle.
- mem_req  output  1  memory access request; held until mem_ready.
- phase  output  2  current phase: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 STORE.
- ld_ir  output  1  one-cycle strobe to load IR.
- ld_pc  output  1  one-cycle strobe to load PC (PC+1).
- ld_reg  output  1  one-cycle strobe to write the register file.
- retire  output  1  one-cycle pulse when an instruction completes.
- running  output  1  high in state RUN.

## Operation
- Control states are IDLE, RUN and HALTED. The phase counter is only meaningful in RUN and reads 0 elsewhere.
- IDLE or HALTED with start=1: go to RUN with phase=0 on the next edge.
- Behaviour per phase in RUN:
  - FETCH: mem_req=1. When mem_ready=1, assert ld_ir and advance. Otherwise hold.
  - DECODE: assert ld_pc and advance unconditionally.
  - EXECUTE, need_mem=1: mem_req=1. Advance when mem_ready=1.
  - EXECUTE, need_mem=0: advance unconditionally with mem_req=0.
  - STORE: assert ld_reg and retire. The phase wraps 3 to 0.
- Halt: halt_req is sampled only in STORE. If it is 1 there, the STORE completes (ld_reg and retire still pulse) and the next state is HALTED with phase=0. halt_req in any other phase has no effect until STORE.
- start and halt_req both high in STORE: halt wins, so the block enters HALTED. If start is still high on the following cycle, it returns to RUN.
- mem_ready while mem_req=0 is ignored.
- mem_req is combinational from the state, the phase and need_mem (Moore-style, no dependence on mem_ready). Every strobe is combinational and is high only during the cycle in which the phase advances.
- Reset at any point, including mid-stall, has these results:
  - State goes to IDLE and phase to 0.
  - mem_req and all strobes go to 0 on the next edge.
  - An outstanding memory access is abandoned.
- Reset values: phase=0, mem_req=0, ld_ir=0, ld_pc=0, ld_reg=0, retire=0, running=0.

## Timing
- The phase advances on the edge that ends the cycle in which its strobe is high. Strobes last exactly one cycle.
- Minimum instruction with mem_ready tied high and need_mem=0 takes 4 cycles. With need_mem=1 and zero-wait memory it also takes 4.
- Each wait cycle (mem_ready=0 while mem_req=1) adds exactly one cycle to FETCH or EXECUTE.
- Back-to-back instructions give one retire every 4 cycles at zero wait.
- Start to first mem_req is 1 cycle after start is sampled.

## Configuration
- CYCLE_CTRL_PERF_EN defined:
  - Adds output retired_cnt (16 bits), which counts retire pulses, wraps from 0xFFFF to 0 and clears on reset.
  - Adds output stall_cnt (16 bits), which counts cycles with mem_req=1 and mem_ready=0, saturates at 0xFFFF and clears on reset.
- CYCLE_CTRL_PERF_EN undefined: neither port exists and no counter logic is built.

## Structure
- Shared package lc3_pkg holds:
  - the control-state enum (IDLE, RUN, HALTED);
  - phase constants PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_STORE=3;
  - the perf counter width constant.
- One sub-module, phase_ctr: a 2-bit wrap counter with inputs incr and synchronous clr (driven by reset or by leaving RUN) and output q. cycle_ctrl drives incr with the "advance" term.

## Test plan
- Reset, then start=1 with mem_ready=1 and need_mem=0 for 12 cycles: expect phase 0,1,2,3 repeating, ld_ir/ld_pc/ld_reg each once per 4 cycles, and retire at cycles 4, 8 and 12.
- FETCH with mem_ready low for 3 cycles: mem_req held for 4 cycles, phase stays 0, ld_ir pulses only in the 4th cycle, instruction takes 7 cycles.
- need_mem=1, EXECUTE with 2 wait cycles: mem_req high in FETCH and for 3 cycles in EXECUTE, instruction takes 6 cycles. need_mem=0 gives mem_req=0 in EXECUTE.
- halt_req raised in DECODE: instruction completes with retire=1 in STORE, then running=0 and phase=0. start=1 resumes with mem_req 1 cycle later.
- Reset asserted mid-FETCH stall: on the next edge phase=0, mem_req=0 and running=0. A later mem_ready pulse produces no ld_ir.
- With CYCLE_CTRL_PERF_EN, run 5 instructions with 3 total wait cycles: retired_cnt=5, stall_cnt=3. Reset clears both to 0.
